// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants, including the divider FSM encoding and the HI/LO writeback codes.
package cpu_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    localparam int DIV_STEPS = 32;

    localparam logic [2:0] WB_SEL_LO = 3'd4;
    localparam logic [2:0] WB_SEL_HI = 3'd5;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] sh_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] sh_o,
    output logic        qbit_o
);
    logic [33:0] shifted;
    logic [33:0] diff;
    always_comb begin
        shifted = {rem_i, sh_i[31]};
        diff    = shifted - {2'b00, dvs_i};
        qbit_o  = ~diff[33];
        rem_o   = qbit_o ? diff[32:0] : shifted[32:0];
        sh_o    = {sh_i[30:0], qbit_o};
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: 34-cycle signed/unsigned 32-bit restoring divider feeding LO (quotient) and HI (remainder).
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

    div_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [32:0]   rem_q, rem_d;
    logic [31:0]   sh_q, sh_d, dvs_q;
    logic          qbit_d;
    logic          signed_q, qneg_q, rneg_q, done_q;
    logic [31:0]   quot_q, remo_q;

    div_step u_step (
        .rem_i (rem_q),
        .sh_i  (sh_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .sh_o  (sh_d),
        .qbit_o(qbit_d)
    );

    // Divide-by-zero keeps the all-ones magnitude quotient unnegated and the remainder equal to the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            sh_q     <= '0;
            dvs_q    <= '0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            quot_q   <= '0;
            remo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DIV_IDLE: if (start && !cancel) begin
                    signed_q <= is_signed;
                    sh_q     <= mag32(dividend, is_signed);
                    dvs_q    <= mag32(divisor, is_signed);
                    qneg_q   <= (dividend[31] ^ divisor[31]) && (divisor != '0);
                    rneg_q   <= dividend[31];
                    rem_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= DIV_RUN;
                end
                DIV_RUN: if (cancel) state_q <= DIV_IDLE;
                else begin
                    rem_q <= rem_d;
                    sh_q  <= {sh_d[31:1], qbit_d};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= DIV_FIX;
                end
                DIV_FIX: begin
                    if (!cancel) begin
                        quot_q <= (signed_q && qneg_q) ? -sh_q : sh_q;
                        remo_q <= (signed_q && rneg_q) ? -rem_q[31:0] : rem_q[31:0];
                        done_q <= 1'b1;
                    end
                    state_q <= DIV_IDLE;
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = state_q != DIV_IDLE;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, cancel, is_signed;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        busy, done;
    int          total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cancel   (cancel),
        .is_signed(is_signed),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input logic [31:0] dd, input logic [31:0] dv, input logic sg);
        start = 1'b1; dividend = dd; divisor = dv; is_signed = sg;
        tick;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic finish_div(input string tag, input logic [31:0] eq, input logic [31:0] er);
        int b0, bc;
        b0 = cyc;
        bc = 0;
        while (!done && cyc < 100) begin
            if (busy) bc++;
            tick;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd34);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'(34 - b0));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
    endtask

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        rst = 1'b0;
        tick;

        go(100, 7, 0);
        chk("run_busy_c1", 32'(busy), 1);
        finish_div("divu_100_7", 14, 2);
        tick;
        chk("done_single", 32'(done), 0);

        go(32'hFFFFFFF9, 2, 1);       finish_div("div_m7_2", 32'hFFFFFFFD, 32'hFFFFFFFF);
        go(7, 32'hFFFFFFFE, 1);       finish_div("div_7_m2", 32'hFFFFFFFD, 1);
        go(32'hFFFFFFF9, 2, 0);       finish_div("divu_big_2", 32'h7FFFFFFC, 1);
        go(32'h80000000, 32'hFFFFFFFF, 1); finish_div("div_min_m1", 32'h80000000, 0);
        go(32'hFFFFFFFF, 1, 0);       finish_div("divu_max_1", 32'hFFFFFFFF, 0);
        go(5, 0, 0);                  finish_div("divu_5_0", 32'hFFFFFFFF, 5);
        go(32'hFFFFFFFB, 0, 1);       finish_div("div_m5_0", 32'hFFFFFFFF, 32'hFFFFFFFB);

        go(100, 7, 0);
        while (cyc < 10) tick;
        start = 1'b1; dividend = 9; divisor = 3;
        tick;
        start = 1'b0;
        finish_div("ignored_start", 14, 2);
        go(9, 3, 0);
        chk("b2b_done_c1", 32'(done), 0);
        finish_div("b2b_9_3", 3, 0);

        go(50, 4, 0);
        while (cyc < 15) tick;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 0);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            tick;
        end
        chk("cancel_no_done", 32'(dn), 0);
        chk("cancel_q_hold", quotient, 3);
        chk("cancel_r_hold", remainder, 0);

        cancel = 1'b1; start = 1'b1; dividend = 50; divisor = 4;
        tick;
        cancel = 1'b0; start = 1'b0;
        chk("cancel_start_idle", 32'(busy), 0);

        go(100, 7, 0);
        while (cyc < 20) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        go(100, 7, 0);
        finish_div("after_rst", 14, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for DIV/DIVU in the 54-instruction pipelined CPU. Accepts operands from the EX stage and runs a 32-step restoring division on operand magnitudes. Raises `busy` so the hazard logic stalls the pipeline. Delivers quotient (to LO) and remainder (to HI); these reach the register file through the 8-way writeback select on MFLO/MFHI.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the parameter exists only for counter sizing.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a divide; sampled only while idle.
- `cancel`  in  1  synchronous abort from pipeline flush or exception.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; latched with the operands.
- `dividend`  in  32  rs value, latched on an accepted start.
- `divisor`  in  32  rt value, latched on an accepted start.
- `busy`  out  1  high while a divide is in progress (states RUN and FIX).
- `done`  out  1  one-cycle pulse; results valid in the same cycle.
- `quotient`  out  32  registered; written to LO.
- `remainder`  out  32  registered; written to HI.

## Operation
States are IDLE, RUN and FIX.

**IDLE**
- `start` = 1 and `cancel` = 0: latch `is_signed`, |dividend|, |divisor|, quotient sign (dividend[31] ^ divisor[31]) and remainder sign (dividend[31]).
  - Sign bits count only when `is_signed` = 1; otherwise they are 0.
  - Clear the 33-bit partial remainder and the 5-bit step counter, then go to RUN.

**RUN**
- Each cycle performs one restoring step:
  - shift {partial remainder, dividend magnitude} left by 1;
  - trial-subtract the divisor magnitude (33-bit);
  - if the trial is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
- After the step with counter = 31, go to FIX.

**FIX**
- Negate the magnitude quotient if the quotient sign is set; negate the magnitude remainder if the remainder sign is set.
- Register `quotient` and `remainder`, set `done` for the next cycle, and return to IDLE.

**Arithmetic and boundary cases**
- Magnitudes are unsigned 32-bit. |0x80000000| = 0x80000000.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Divisor 0 runs the full sequence and yields quotient 0xFFFFFFFF, remainder = dividend (unmodified, any signedness). No exception.
- `start` while `busy`: ignored. The hazard unit guarantees it is not issued.
- `cancel` in RUN or FIX: return to IDLE next edge. No `done`; `quotient`/`remainder` keep their previous values.
- `cancel` together with `start` in IDLE: the start is not accepted.
- `rst` at any time: state IDLE, `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, internal registers cleared. `rst` has priority over `cancel` and `start`.

## Timing
- Cycle 0: `start` = 1 while idle. This cycle is not covered by `busy`, so the hazard unit must stall on (`start` | `busy`).
- Cycles 1–32: RUN, `busy` = 1.
- Cycle 33: FIX, `busy` = 1.
- Cycle 34: `done` = 1, `busy` = 0, results valid. Fixed latency is 34 cycles from start to done.
- A new `start` in cycle 34 is accepted; back-to-back throughput is one divide per 34 cycles.
- `quotient`/`remainder` hold until the next `done` or `rst`.
- `done` never asserts for two consecutive cycles.

## Structure
- Shared package `cpu_pkg`:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2);
  - `DIV_STEPS` = 32;
  - the LO/HI writeback-select codes used by the 8-way writeback select.
- One natural sub-module, `div_step`: purely combinational, one restoring iteration. Inputs are a 33-bit partial remainder, a 32-bit dividend shift register and a 32-bit divisor. Outputs are the next remainder, the next shift register and the quotient bit.
- `div_unit` holds the FSM, counter, operand/sign registers and the output registers.

## Test plan
- DIVU 100 / 7: `done` exactly 34 cycles after start; quotient 14, remainder 2; `busy` high cycles 1–33 only.
- DIV −7 (0xFFFFFFF9) / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2: quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- DIVU 5 / 0: quotient 0xFFFFFFFF, remainder 5. DIV 0xFFFFFFFB / 0: quotient 0xFFFFFFFF, remainder 0xFFFFFFFB.
- Start 100 / 7; `start` again in cycle 10 with 9 / 3: ignored, result 14/2. Then `start` 9 / 3 in the `done` cycle: accepted, result 3/0 at +34.
- `cancel` in cycle 15: `busy` 0 at cycle 16, no `done`, outputs keep prior values. Separately, `rst` in cycle 20: all outputs 0 next cycle, and a fresh start completes normally.
